// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ==== serial_addsub_ctrl : bit-serial WIDTH-bit add/sub sequencer driving a fas cell (rev 1.0) ====
// ==== Optional OVERFLOW_EN macro adds the signed-overflow output ovf                            ====
module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             add_nsub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   output logic             fa_ans,
   input  logic             fa_s,
   input  logic             fa_cout
`ifdef OVERFLOW_EN
   ,output logic            ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             op_l;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             last;

   assign last   = (cnt == CNT_W'(WIDTH - 1));
   assign fa_cin = carry;
   assign fa_ans = op_l;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            fa_a = a_sh[0];
            fa_b = b_sh[0];
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef OVERFLOW_EN
   logic cin_msb;

   // Signed overflow is carry-into-MSB xor carry-out; the same holds for the borrow chain.
   assign ovf = cin_msb ^ carry_out;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         op_l      <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
`ifdef OVERFLOW_EN
         cin_msb   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= op_a;
                  b_sh  <= op_b;
                  op_l  <= add_nsub;
                  carry <= 1'b0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               result <= {fa_s, result[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_cout;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  carry_out <= fa_cout;
`ifdef OVERFLOW_EN
                  cin_msb   <= carry;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ==== tb_serial_addsub_ctrl : scoreboard bench for serial_addsub_ctrl with a behavioural fas cell (rev 1.0) ====
module tb_serial_addsub_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] op_a = '0;
   logic [WIDTH-1:0] op_b = '0;
   logic             add_nsub = 1'b0;
   logic             busy, done, carry_out;
   logic [WIDTH-1:0] result;
   logic             fa_a, fa_b, fa_cin, fa_ans, fa_s, fa_cout;
`ifdef OVERFLOW_EN
   logic             ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             c;
      logic             v;
   } exp_t;
   exp_t sb[$];

   serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .add_nsub(add_nsub), .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
      .fa_ans(fa_ans), .fa_s(fa_s), .fa_cout(fa_cout)
`ifdef OVERFLOW_EN
      , .ovf(ovf)
`endif
   );

   // Full adder/subtractor cell: cout is carry on add, borrow on subtract.
   assign fa_s    = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = fa_ans ? ((fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b)))
                           : ((~fa_a & fa_b) | (~(fa_a ^ fa_b) & fa_cin));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("carry_out", 32'(carry_out), 32'(e.c));
`ifdef OVERFLOW_EN
            chk("ovf", 32'(ovf), 32'(e.v));
`endif
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   // Issues one start; leaves the bench at the negedge just after the accepting edge.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic add,
                        input logic push, input logic [WIDTH-1:0] res, input logic c, input logic v);
      exp_t e;
      wait_idle();
      start    = 1'b1;
      op_a     = a;
      op_b     = b;
      add_nsub = add;
      if (push) begin
         e.res = res; e.c = c; e.v = v;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      op_a  = ~a;
      op_b  = ~b;
   endtask

   // Full operation with latency and continuous-busy checks.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic add,
                         input logic [WIDTH-1:0] res, input logic c, input logic v);
      int k = 0;
      int busy_gaps = 0;
      issue(a, b, add, 1'b1, res, c, v);
      while (!done && k < 100) begin
         if (!busy) busy_gaps++;
         @(negedge clk);
         k++;
      end
      chk("latency", 32'(k), 32'(WIDTH));
      chk("busy_continuous", 32'(busy_gaps), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      chk("rst_fa_a", 32'(fa_a), 32'd0);
      chk("rst_fa_cin", 32'(fa_cin), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(8'h35, 8'h4A, 1'b1, 8'h7F, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
      run_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      run_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op(8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1);
      run_op(8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op(8'h10, 8'h10, 1'b1, 8'h20, 1'b0, 1'b0);

      // Start during RUN is ignored: one done, result of the first op only.
      issue(8'h01, 8'h02, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1; op_a = 8'hAA; op_b = 8'h55; add_nsub = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("ignored_start_idle", 32'(busy), 32'd0);

      // Reset mid-RUN aborts without a done pulse.
      issue(8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_carry", 32'(carry_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      run_op(8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
